// File: rtl/id_stage.sv
// id_stage: RV32I decode with write-back bypass, load-use detection and ID/EX register
module id_stage #(
  parameter bit BYPASS_EN = 1'b1,
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_hold,
  input  logic        ex_flush,
  output logic        stall_if,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_funct3,
  output logic        ex_funct7b5,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_illegal
);
  logic [6:0]  op;
  logic [4:0]  rd;
  logic        is_r, is_i, is_ld, is_s, is_b, is_u, is_j, illegal;
  logic        uses_rs1, uses_rs2, reg_write, lu, bubble_ill, go;
  logic [31:0] imm, op1, op2;
  logic [31:0] ins;
  assign ins = if_instr;
  assign op = ins[6:0];
  assign rd = ins[11:7];
  assign rs1_addr = ins[19:15];
  assign rs2_addr = ins[24:20];
  assign is_r = op == 7'b0110011;
  assign is_ld = op == 7'b0000011;
  assign is_i = op == 7'b0010011 || is_ld || op == 7'b1100111;
  assign is_s = op == 7'b0100011;
  assign is_b = op == 7'b1100011;
  assign is_u = op == 7'b0110111 || op == 7'b0010111;
  assign is_j = op == 7'b1101111;
  assign illegal = ~(is_r | is_i | is_s | is_b | is_u | is_j);
  assign uses_rs1 = is_r | is_i | is_s | is_b;
  assign uses_rs2 = is_r | is_s | is_b;
  assign reg_write = (is_r | is_i | is_u | is_j) & (rd != 5'd0);
  always_comb begin
    imm = is_i ? {{20{ins[31]}}, ins[31:20]} :
          is_s ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
          is_b ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
          is_u ? {ins[31:12], 12'b0} :
          is_j ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} : 32'd0;
    op1 = rs1_addr == 5'd0 ? 32'd0 :
          (BYPASS_EN && wb_we && wb_rd == rs1_addr) ? wb_data : rs1_data;
    op2 = rs2_addr == 5'd0 ? 32'd0 :
          (BYPASS_EN && wb_we && wb_rd == rs2_addr) ? wb_data : rs2_data;
  end
  assign lu = ex_valid & ex_mem_read & (ex_rd != 5'd0) & if_valid &
              ((uses_rs1 & (ex_rd == rs1_addr)) | (uses_rs2 & (ex_rd == rs2_addr)));
  assign stall_if = ~ex_flush & (ex_hold | lu);
  assign bubble_ill = ~ex_flush & ~lu & if_valid & illegal & NOP_ON_ILLEGAL;
  assign go = if_valid & ~ex_flush & ~lu & ~(illegal & NOP_ON_ILLEGAL);
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_pc <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_imm <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      ex_rd <= '0;
      ex_opcode <= '0;
      ex_funct3 <= '0;
      ex_funct7b5 <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (ex_flush || !ex_hold) begin
      ex_valid <= go;
      ex_pc <= if_pc;
      ex_rs1_val <= op1;
      ex_rs2_val <= op2;
      ex_imm <= imm;
      ex_rs1 <= rs1_addr;
      ex_rs2 <= rs2_addr;
      ex_rd <= rd;
      ex_opcode <= op;
      ex_funct3 <= ins[14:12];
      ex_funct7b5 <= ins[30];
      ex_reg_write <= go & reg_write;
      ex_mem_read <= go & is_ld;
      ex_mem_write <= go & is_s;
      ex_illegal <= bubble_ill;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed checks of the id_stage decode/bypass/hazard/pipeline behaviour
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst, if_valid, wb_we, ex_hold, ex_flush;
  logic [31:0] if_instr, if_pc, rs1_data, rs2_data, wb_data;
  logic [4:0]  wb_rd, rs1_addr, rs2_addr;
  logic        stall_if, ex_valid, ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  int checks = 0;
  int errors = 0;
  id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ex_hold(ex_hold), .ex_flush(ex_flush),
    .stall_if(stall_if), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_illegal(ex_illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; if_valid = 1'b1; if_instr = 32'hFFF08293; if_pc = 32'h100;
    rs1_data = 32'd0; rs2_data = 32'd0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    ex_hold = 1'b0; ex_flush = 1'b0;
    step(); step();
    chk("rst_valid", ex_valid, 0);
    chk("rst_rs1_val", ex_rs1_val, 0);
    chk("rst_imm", ex_imm, 0);
    rst = 1'b0; rs1_data = 32'd1;
    #1 chk("rs1_addr", rs1_addr, 1);
    step();
    chk("addi_rs1_val", ex_rs1_val, 1);
    chk("addi_imm", ex_imm, 32'hFFFFFFFF);
    chk("addi_rd", ex_rd, 5);
    chk("addi_rw", ex_reg_write, 1);
    chk("addi_valid", ex_valid, 1);
    chk("addi_pc", ex_pc, 32'h100);
    if_instr = 32'h002081B3; rs2_data = 32'd2; wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEADBEEF;
    step();
    chk("byp_rs2", ex_rs2_val, 32'hDEADBEEF);
    chk("byp_rs1", ex_rs1_val, 1);
    wb_rd = 5'd0;
    step();
    chk("nobyp_rs2", ex_rs2_val, 2);
    wb_we = 1'b0;
    if_instr = 32'h0000A203;
    step();
    chk("lw_mem_read", ex_mem_read, 1);
    chk("lw_rd", ex_rd, 4);
    if_instr = 32'h00420333;
    #1 chk("lu_stall", stall_if, 1);
    step();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_stall_clear", stall_if, 0);
    step();
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_rd", ex_rd, 6);
    if_instr = 32'h0000A203;
    step();
    if_instr = 32'h12345237;
    #1 chk("lui_nostall", stall_if, 0);
    step();
    chk("lui_valid", ex_valid, 1);
    chk("lui_imm", ex_imm, 32'h12345000);
    if_instr = 32'hFE20AE23;
    step();
    chk("sw_imm", ex_imm, 32'hFFFFFFFC);
    chk("sw_mem_write", ex_mem_write, 1);
    chk("sw_rw", ex_reg_write, 0);
    if_instr = 32'h00208463;
    step();
    chk("beq_imm", ex_imm, 8);
    if_instr = 32'h801FF0EF;
    step();
    chk("jal_imm", ex_imm, 32'hFFFFF800);
    chk("jal_rw", ex_reg_write, 1);
    ex_hold = 1'b1; if_instr = 32'hFFF08293;
    #1 chk("hold_stall", stall_if, 1);
    step(); step(); step();
    chk("hold_imm", ex_imm, 32'hFFFFF800);
    chk("hold_rd", ex_rd, 1);
    chk("hold_valid", ex_valid, 1);
    chk("hold_stall3", stall_if, 1);
    ex_flush = 1'b1;
    #1 chk("hf_stall", stall_if, 0);
    step();
    chk("hf_valid", ex_valid, 0);
    ex_hold = 1'b0; ex_flush = 1'b0;
    if_instr = 32'h0000A203;
    step();
    if_instr = 32'h00420333; ex_flush = 1'b1;
    #1 chk("flu_stall", stall_if, 0);
    step();
    chk("flu_valid", ex_valid, 0);
    ex_flush = 1'b0;
    if_instr = 32'h0000007F;
    step();
    chk("ill_valid", ex_valid, 0);
    chk("ill_flag", ex_illegal, 1);
    if_instr = 32'h00208033;
    step();
    chk("ill_clear", ex_illegal, 0);
    chk("x0_rw", ex_reg_write, 0);
    chk("x0_valid", ex_valid, 1);
    if_instr = 32'h002003B3; rs1_data = 32'd5;
    step();
    chk("x0_rs1_val", ex_rs1_val, 0);
    chk("x0_rs2_val", ex_rs2_val, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I instruction-decode stage that sits directly downstream of the register file.
- Drives the register-file read addresses from the fetched instruction. Consumes the asynchronous read data and applies a same-cycle write-back bypass.
- Decodes immediates and control, detects load-use hazards, and registers everything into the ID/EX pipeline register with hold and flush.

Parameters:
- BYPASS_EN, 1, 1 = forward wb_data to the operands when the WB write targets a register read this cycle; 0 = no bypass.
- NOP_ON_ILLEGAL, 1, 1 = an unrecognised opcode enters EX as a bubble with ex_illegal=1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- if_valid  in  1  if_instr/if_pc hold a valid instruction
- if_instr  in  32  instruction word
- if_pc  in  32  instruction address
- rs1_addr  out  5  register-file read_reg1 = if_instr[19:15], combinational
- rs2_addr  out  5  register-file read_reg2 = if_instr[24:20], combinational
- rs1_data  in  32  register-file read_data1
- rs2_data  in  32  register-file read_data2
- wb_we  in  1  write-back enable (same signal as register-file reg_write)
- wb_rd  in  5  write-back destination
- wb_data  in  32  write-back data
- ex_hold  in  1  EX cannot accept; freeze ID/EX
- ex_flush  in  1  taken branch/jump; kill ID and ID/EX contents
- stall_if  out  1  combinational; IF must hold PC and instruction
- ex_valid  out  1  ID/EX holds a live instruction
- ex_pc  out  32
- ex_rs1_val  out  32
- ex_rs2_val  out  32
- ex_imm  out  32  sign-extended immediate
- ex_rs1  out  5
- ex_rs2  out  5
- ex_rd  out  5
- ex_opcode  out  7
- ex_funct3  out  3
- ex_funct7b5  out  1  instr[30]
- ex_reg_write  out  1
- ex_mem_read  out  1
- ex_mem_write  out  1
- ex_illegal  out  1

Behaviour:
- Clock is clk. Reset is rst, synchronous, active-high.
- Reset: every ex_* register is 0, including ex_valid=0.
- Latency: an instruction presented in cycle N appears on ex_* after the rising edge ending cycle N.
- The read-address outputs rs1_addr and rs2_addr are always driven from if_instr, whether or not if_valid is set.
- Operand selection, per source (BYPASS_EN=1):
  - If the source address is 0, the operand is 0.
  - Else if wb_we and wb_rd equals the source address, the operand is wb_data.
  - Otherwise the operand is rsN_data.
  - Reason: the register file writes on the clock edge, so a same-cycle read returns the old value.
- Opcode classes:
  - R 0110011: imm=0, uses rs1 and rs2, reg_write=1.
  - I 0010011, 0000011 (load, mem_read=1), 1100111: imm=sext(instr[31:20]), uses rs1, reg_write=1.
  - S 0100011: imm=sext({instr[31:25],instr[11:7]}), uses rs1 and rs2, mem_write=1.
  - B 1100011: imm=sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}), uses rs1 and rs2.
  - U 0110111, 0010111: imm={instr[31:12],12'b0}, reg_write=1.
  - J 1101111: imm=sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}), reg_write=1.
  - Any other opcode is illegal.
- ex_reg_write is forced to 0 when rd is 0.
- Load-use hazard, named lu:
  - lu = ex_valid & ex_mem_read & (ex_rd≠0) & if_valid & ((uses_rs1 & ex_rs1 target match) | (uses_rs2 & match)).
  - Here "match" means ex_rd == instr[19:15] for rs1 and ex_rd == instr[24:20] for rs2.
- stall_if = ~ex_flush & (ex_hold | lu).
- Per-edge priority, highest first:
  1. rst: clear all ex_* registers.
  2. ex_flush: ex_valid←0 and all control bits←0; the ID instruction is discarded (IF redirects).
  3. ex_hold: all ex_* hold their values.
  4. lu: insert a bubble (ex_valid←0, control bits←0); the ID instruction is re-presented next cycle.
  5. Illegal opcode with if_valid and NOP_ON_ILLEGAL=1: bubble with ex_illegal←1 for one cycle.
  6. Otherwise: capture the decoded instruction, with ex_valid←if_valid and control bits gated by if_valid.
- ex_illegal is 0 in every case other than step 5.
- Under ex_hold, the held operands are not re-bypassed; a write-back during the hold is visible to the instruction waiting in ID through the normal path.

Test Plan:
- Reset: assert rst for 2 cycles with if_valid=1 → ex_valid=0, ex_rs1_val=0, ex_imm=0; after release, addi x5,x1,-1 (0xFFF08293) with rs1_data=1 → next cycle ex_rs1_val=1, ex_imm=0xFFFFFFFF, ex_rd=5, ex_reg_write=1.
- Bypass: add x3,x1,x2 with rs1_data=1, rs2_data=2, and wb_we=1, wb_rd=2, wb_data=0xDEADBEEF → ex_rs2_val=0xDEADBEEF, ex_rs1_val=1. Repeat with wb_rd=0 → ex_rs2_val=2.
- Load-use: lw x4,0(x1), then add x6,x4,x4 → stall_if=1 for 1 cycle, one bubble (ex_valid=0), then add captured; lw x4 followed by lui x4 → no stall.
- Immediates: sw with offset -4 → ex_imm=0xFFFFFFFC, ex_mem_write=1. beq with offset +8 → ex_imm=8. jal with offset -2048 → ex_imm=0xFFFFF800. lui 0x12345 → ex_imm=0x12345000.
- Hold vs flush: assert ex_hold for 3 cycles → ex_* unchanged and stall_if=1. Assert ex_hold and ex_flush together → ex_valid=0 next cycle and stall_if=0. A flush coinciding with lu → bubble and stall_if=0.
- Illegal/x0: opcode 0x7F → one cycle with ex_valid=0 and ex_illegal=1. add x0,x1,x2 → ex_reg_write=0. rs1=x0 with rs1_data=5 → ex_rs1_val=0.
